// File: rtl/log_corr_pkg.sv
// Shared types and the log-to-linear helper for the log-domain correlator array.
package log_corr_pkg;

    localparam int LC_INT_W  = 5;
    localparam int LC_FRAC_W = 27;

    typedef struct packed {
        logic                           zero;
        logic                           sign;
        logic [LC_INT_W+LC_FRAC_W-1:0]  lg;
    } log_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lc_state_e;

    // lsum carries the raw log sum (one carry bit above int_w integer bits);
    // returns 2^int with the fraction truncated below it, clamped to the accumulator max.
    function automatic logic [31:0] ilog2(input logic [63:0] lsum, input int int_w,
                                          input int frac_w, input int acc_w);
        logic [63:0] ipart;
        logic [63:0] frac;
        logic [63:0] mant;
        logic [31:0] res;
        ipart = lsum >> frac_w;
        frac  = lsum & ((64'd1 << frac_w) - 64'd1);
        if (((ipart >> int_w) != 64'd0) || (ipart > 64'(acc_w - 2))) begin
            res = (32'd1 << (acc_w - 1)) - 32'd1;
        end else begin
            mant = (64'd1 << frac_w) | frac;
            mant = (mant << ipart) >> frac_w;
            res  = mant[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/log_corr_pe.sv
// One correlator tap: descriptor register, log-domain product and accumulator stage.
// Define LOG_CORR_SAT_EN to saturate the accumulator addition instead of wrapping.
module log_corr_pe
    import log_corr_pkg::*;
#(
    parameter int INT_W  = 5,
    parameter int FRAC_W = 27,
    parameter int ACC_W  = 16,
    localparam int LW    = INT_W + FRAC_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tap_we,
    input  logic [LW-1:0]           tap_in,
    input  logic                    en,
    input  logic                    clr,
    input  logic [LW-1:0]           x_in,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out
);

    localparam int LOG_W = INT_W + FRAC_W;

    logic [LW-1:0]           tap_r;
    logic [LOG_W:0]          lsum_s;
    logic [31:0]             mag_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W:0]   wide_s;
    logic signed [ACC_W-1:0] sum_s;

    // Product of tap and broadcast sample
    always_comb begin
        lsum_s = {1'b0, tap_r[LOG_W-1:0]} + {1'b0, x_in[LOG_W-1:0]};
        mag_s  = ilog2(64'(lsum_s), INT_W, FRAC_W, ACC_W);
        if (tap_r[LW-1] || x_in[LW-1]) begin
            prod_s = {ACC_W{1'b0}};
        end else if (tap_r[LW-2] ^ x_in[LW-2]) begin
            prod_s = -$signed(mag_s[ACC_W-1:0]);
        end else begin
            prod_s = $signed(mag_s[ACC_W-1:0]);
        end
    end

    // Accumulate the incoming partial sum with this tap's product
    always_comb begin
        wide_s = {acc_in[ACC_W-1], acc_in} + {prod_s[ACC_W-1], prod_s};
`ifdef LOG_CORR_SAT_EN
        if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
            sum_s = wide_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum_s = wide_s[ACC_W-1:0];
        end
`else
        sum_s = wide_s[ACC_W-1:0];
`endif
    end

    // Tap storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_r <= {LW{1'b0}};
        end else if (tap_we) begin
            tap_r <= tap_in;
        end
    end

    // Partial-sum register; holds on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_out <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_out <= sum_s;
        end
    end

endmodule

// File: rtl/log_corr_array.sv
// Transposed-form log-domain correlator: loads NUM_PE descriptor taps, then streams a window.
// Accumulator behaviour is selected by LOG_CORR_SAT_EN (saturate) or its absence (wrap).
module log_corr_array
    import log_corr_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int INT_W  = 5,
    parameter int FRAC_W = 27,
    parameter int ACC_W  = 16,
    localparam int LW    = INT_W + FRAC_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [LW-1:0]           desc_in,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [LW-1:0]           win_in,
    output logic                    acc_valid,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    busy
);

    localparam int CNT_W = $clog2(NUM_PE + 1);

    lc_state_e               state_r;
    lc_state_e               state_nx;
    logic [CNT_W-1:0]        desc_cnt_r;
    logic [CNT_W-1:0]        fill_cnt_r;
    logic                    acc_valid_r;
    logic                    desc_fire_s;
    logic                    desc_last_s;
    logic                    win_fire_s;
    logic                    clr_s;
    logic signed [ACC_W-1:0] chain_s [NUM_PE+1];

    assign desc_fire_s = desc_valid && desc_ready;
    assign desc_last_s = desc_fire_s && (desc_cnt_r == CNT_W'(NUM_PE - 1));
    assign clr_s       = restart && (state_r == ST_RUN);
    assign win_fire_s  = win_valid && (state_r == ST_RUN) && !restart;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (desc_last_s) begin
                    state_nx = ST_RUN;
                end else if (desc_fire_s) begin
                    state_nx = ST_LOAD;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_RUN: begin
                if (restart) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        desc_ready = 1'b0;
        win_ready  = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_IDLE: desc_ready = 1'b1;
            ST_LOAD: begin
                desc_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_RUN: begin
                win_ready = 1'b1;
                busy      = 1'b1;
            end
            default: desc_ready = 1'b0;
        endcase
    end

    // Descriptor write pointer; wraps to zero as RUN is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_cnt_r <= {CNT_W{1'b0}};
        end else if (desc_last_s) begin
            desc_cnt_r <= {CNT_W{1'b0}};
        end else if (desc_fire_s) begin
            desc_cnt_r <= desc_cnt_r + CNT_W'(1);
        end
    end

    // Pipeline fill tracking and result-valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_r  <= {CNT_W{1'b0}};
            acc_valid_r <= 1'b0;
        end else if (clr_s) begin
            fill_cnt_r  <= {CNT_W{1'b0}};
            acc_valid_r <= 1'b0;
        end else begin
            acc_valid_r <= win_fire_s && (fill_cnt_r == CNT_W'(NUM_PE - 1));
            if (win_fire_s && (fill_cnt_r < CNT_W'(NUM_PE - 1))) begin
                fill_cnt_r <= fill_cnt_r + CNT_W'(1);
            end
        end
    end

    assign chain_s[0] = {ACC_W{1'b0}};

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        log_corr_pe #(
            .INT_W  (INT_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clk     (clk),
            .rst     (rst),
            .tap_we  (desc_fire_s && (desc_cnt_r == CNT_W'(k))),
            .tap_in  (desc_in),
            .en      (win_fire_s),
            .clr     (clr_s),
            .x_in    (win_in),
            .acc_in  (chain_s[k]),
            .acc_out (chain_s[k+1])
        );
    end

    assign acc_out   = chain_s[NUM_PE];
    assign acc_valid = acc_valid_r;

endmodule

// File: tb/tb_log_corr_array.sv
// Scoreboard bench for log_corr_array: directed descriptors/windows, queue-based result checking.
module tb_log_corr_array;
    import log_corr_pkg::*;

    localparam log_word_t W_P1   = '{zero: 1'b0, sign: 1'b0, lg: 32'h0000_0000};
    localparam log_word_t W_N1   = '{zero: 1'b0, sign: 1'b1, lg: 32'h0000_0000};
    localparam log_word_t W_P2   = '{zero: 1'b0, sign: 1'b0, lg: 32'h0800_0000};
    localparam log_word_t W_P3   = '{zero: 1'b0, sign: 1'b0, lg: 32'h0CAE_147A};
    localparam log_word_t W_P8   = '{zero: 1'b0, sign: 1'b0, lg: 32'h1800_0000};
    localparam log_word_t W_BIG  = '{zero: 1'b0, sign: 1'b0, lg: 32'hF800_0000};
    localparam log_word_t W_ZERO = '{zero: 1'b1, sign: 1'b0, lg: 32'h0000_0000};

`ifdef LOG_CORR_SAT_EN
    localparam int EXP_BIG = 32767;
    localparam int EXP_8   = 127;
`else
    localparam int EXP_BIG = -16;
    localparam int EXP_8   = 0;
`endif

    logic clk = 1'b0;
    logic rst, restart, desc_valid, win_valid, en8;
    logic [33:0] desc_in, win_in;
    logic desc_ready, win_ready, acc_valid, busy;
    logic signed [15:0] acc_out;
    logic desc_ready8, win_ready8, acc_valid8, busy8;
    logic signed [7:0] acc_out8;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int exp_q8[$];
    int e_m, e_m8;
    logic [33:0] desc_v [16];

    always #5 clk = ~clk;

    log_corr_array dut (
        .clk(clk), .rst(rst), .restart(restart),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_in(desc_in),
        .win_valid(win_valid), .win_ready(win_ready), .win_in(win_in),
        .acc_valid(acc_valid), .acc_out(acc_out), .busy(busy)
    );

    log_corr_array #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .restart(restart),
        .desc_valid(desc_valid && en8), .desc_ready(desc_ready8), .desc_in(desc_in),
        .win_valid(win_valid && en8), .win_ready(win_ready8), .win_in(win_in),
        .acc_valid(acc_valid8), .acc_out(acc_out8), .busy(busy8)
    );

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitors: every acc_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && acc_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL acc_unexpected: got=%0d want=no_output", acc_out);
            end else begin
                e_m = exp_q.pop_front();
                chk("acc16", int'(acc_out), e_m);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && acc_valid8) begin
            if (exp_q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL acc8_unexpected: got=%0d want=no_output", acc_out8);
            end else begin
                e_m8 = exp_q8.pop_front();
                chk("acc8", int'(acc_out8), e_m8);
            end
        end
    end

    task automatic set_all(input logic [33:0] w);
        for (int k = 0; k < 16; k++) desc_v[k] = w;
    endtask

    task automatic load_desc();
        for (int k = 0; k < 16; k++) begin
            desc_valid = 1'b1;
            desc_in    = desc_v[k];
            @(posedge clk); #1;
        end
        desc_valid = 1'b0;
        chk("run_entry_win_ready", int'(win_ready), 1);
        chk("run_entry_desc_ready", int'(desc_ready), 0);
    endtask

    task automatic send(input logic [33:0] x, input bit has_exp, input int expv, input bit stall);
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                win_valid = 1'b0;
                win_in    = 34'($urandom());
                @(posedge clk); #1;
            end
        end
        if (has_exp) exp_q.push_back(expv);
        win_valid = 1'b1;
        win_in    = x;
        @(posedge clk); #1;
        win_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("restart_busy", int'(busy), 0);
    endtask

    // Uniform window of n samples; results expected from the 16th onward
    task automatic run_const(input logic [33:0] x, input int n, input int expv);
        for (int i = 1; i <= n; i++) send(x, i >= 16, expv, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_exp [5];
        seq_exp = '{16, 14, 12, 10, 8};
        rst = 1'b1; restart = 1'b0; desc_valid = 1'b0; win_valid = 1'b0; en8 = 1'b0;
        desc_in = 34'd0; win_in = 34'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_desc_ready", int'(desc_ready), 1);
        chk("rst_win_ready", int'(win_ready), 0);
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // +1 taps, +1 window: first result on sample 16, held through 20
        set_all(W_P1); load_desc();
        run_const(W_P1, 20, 16); do_restart();
        // +3 taps x +1 -> 3 each
        set_all(W_P3); load_desc();
        run_const(W_P1, 16, 48); do_restart();
        // negative taps
        set_all(W_N1); load_desc();
        run_const(W_P3, 16, -48); do_restart();
        // alternating signs cancel
        for (int k = 0; k < 16; k++) desc_v[k] = (k % 2 == 1) ? W_N1 : W_P1;
        load_desc();
        run_const(W_P2, 16, 0); do_restart();
        // zero-flagged window
        set_all(W_P1); load_desc();
        run_const(W_ZERO, 16, 0); do_restart();
        // log-sum carry clamps each product to 32767
        set_all(W_BIG); load_desc();
        run_const(W_P2, 16, EXP_BIG); do_restart();

        // 8-bit accumulator instance alongside the default one
        en8 = 1'b1;
        set_all(W_P8); load_desc();
        chk("acc8_win_ready", int'(win_ready8), 1);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) exp_q8.push_back(EXP_8);
            send(W_P8, i == 16, 1024, 1'b0);
        end
        do_restart();
        en8 = 1'b0;
        chk("acc8_busy_after_restart", int'(busy8), 0);

        // Sliding sum, stall-free then with random stalls
        for (int pass = 0; pass < 2; pass++) begin
            set_all(W_P1); load_desc();
            for (int i = 1; i <= 20; i++)
                send((i <= 16) ? W_P1 : W_N1, i >= 16, (i >= 16) ? seq_exp[i-16] : 0, pass == 1);
            do_restart();
        end

        // Restart after 10 samples, colliding with win_valid
        set_all(W_P1); load_desc();
        run_const(W_P1, 10, 0);
        restart = 1'b1; win_valid = 1'b1; win_in = W_P1;
        @(posedge clk); #1;
        restart = 1'b0; win_valid = 1'b0;
        chk("abort_win_ready", int'(win_ready), 0);
        chk("abort_desc_ready", int'(desc_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_acc_valid", int'(acc_valid), 0);
        chk("abort_acc_out", int'(acc_out), 0);
        load_desc();
        run_const(W_P1, 16, 16); do_restart();

        // Reset in the middle of a descriptor load
        for (int k = 0; k < 5; k++) begin
            desc_valid = 1'b1; desc_in = W_P2;
            @(posedge clk); #1;
        end
        chk("midload_busy", int'(busy), 1);
        rst = 1'b1; desc_valid = 1'b0;
        #2;
        chk("midload_rst_desc_ready", int'(desc_ready), 1);
        chk("midload_rst_win_ready", int'(win_ready), 0);
        chk("midload_rst_acc_valid", int'(acc_valid), 0);
        chk("midload_rst_acc_out", int'(acc_out), 0);
        chk("midload_rst_busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Tap order: only d[0] live, so sample 16 sees x[1]
        set_all(W_ZERO); desc_v[0] = W_P2; load_desc();
        send(W_P3, 1'b0, 0, 1'b0);
        for (int i = 2; i <= 18; i++) begin
            send(W_P1, i >= 16, (i == 16) ? 6 : 2, 1'b0);
        end
        do_restart();

        repeat (5) @(posedge clk);
        chk("drain_q16", exp_q.size(), 0);
        chk("drain_q8", exp_q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
